// File: rtl/fir_pkg.sv
// Shared FIR definitions: scheduler state encoding, default sizes and a clog2 helper.
// Also used by the direct-form filter, so the defaults live here.
package fir_pkg;

  localparam int unsigned FirN  = 16;
  localparam int unsigned FirDw = 16;

  typedef enum logic {
    StIdle,
    StMac
  } fir_state_e;

  function automatic int unsigned fir_clog2(input int unsigned v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate: DW x DW product sign-extended into an ACC_W accumulator.
// o_sum exposes acc + product so the caller can capture the final tap without an extra cycle.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int unsigned DW    = FirDw,
  parameter int unsigned ACC_W = 2 * FirDw + 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [DW-1:0]    i_a,
  input  logic signed [DW-1:0]    i_b,
  output logic signed [ACC_W-1:0] o_acc,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = (2 * DW)'(i_a) * (2 * DW)'(i_b);
  assign w_prod_ext = {{(ACC_W - 2 * DW){w_prod[2*DW-1]}}, w_prod};
  assign o_sum      = r_acc + w_prod_ext;
  assign o_acc      = r_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fir_serial_mac_sched.sv
// Time-multiplexed FIR controller: one shared MAC sequenced over N taps per accepted sample.
// Owns the coefficient RAM and the circular sample history.
module fir_serial_mac_sched
  import fir_pkg::*;
#(
  parameter  int unsigned N     = FirN,
  parameter  int unsigned DW    = FirDw,
  localparam int unsigned AW    = fir_clog2(N),
  localparam int unsigned ACC_W = 2 * DW + AW
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_coeff_wr,
  input  logic [AW-1:0]           i_coeff_addr,
  input  logic signed [DW-1:0]    i_coeff_in,
  input  logic                    i_x_valid,
  input  logic signed [DW-1:0]    i_x_in,
  output logic                    o_x_ready,
  output logic                    o_y_valid,
  output logic signed [ACC_W-1:0] o_y_out,
  output logic                    o_busy
);

  fir_state_e              r_state;
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rd;
  logic [AW-1:0]           r_k;
  logic signed [DW-1:0]    r_hist  [N];
  logic signed [DW-1:0]    r_coeff [N];
  logic signed [ACC_W-1:0] r_y_out;
  logic                    r_y_valid;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_addr_ok;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [ACC_W-1:0] w_sum;

  // coeff_wr wins over a sample offered in the same cycle
  assign o_x_ready = (r_state == StIdle) && !i_coeff_wr;
  assign w_accept  = o_x_ready && i_x_valid;
  assign w_last    = (r_k == AW'(N - 1));
  assign w_addr_ok = (32'(i_coeff_addr) < N);
  assign o_busy    = (r_state == StMac);
  assign o_y_out   = r_y_out;
  assign o_y_valid = r_y_valid;

  fir_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_accept),
    .i_en  (r_state == StMac),
    .i_a   (r_hist[r_rd]),
    .i_b   (r_coeff[r_k]),
    .o_acc (w_acc),
    .o_sum (w_sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_wptr    <= '0;
      r_rd      <= '0;
      r_k       <= '0;
      r_y_out   <= '0;
      r_y_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_hist[i]  <= '0;
        r_coeff[i] <= '0;
      end
    end else begin
      r_y_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_coeff_wr) begin
            if (w_addr_ok) r_coeff[i_coeff_addr] <= i_coeff_in;
          end else if (i_x_valid) begin
            r_hist[r_wptr] <= i_x_in;
            r_rd           <= r_wptr;
            r_k            <= '0;
            r_state        <= StMac;
          end
        end
        StMac: begin
          // Walk the history backwards from the newest sample, wrapping modulo N
          r_rd <= (r_rd == '0) ? AW'(N - 1) : r_rd - AW'(1);
          r_k  <= r_k + AW'(1);
          if (w_last) begin
            r_y_out   <= w_sum;
            r_y_valid <= 1'b1;
            r_wptr    <= (r_wptr == AW'(N - 1)) ? '0 : r_wptr + AW'(1);
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/fir_serial_mac_sched.md
Name: fir_serial_mac_sched

Overview:
Time-multiplexed FIR engine controller. It replaces an N-multiplier direct-form filter with one shared multiply-accumulate unit that is sequenced over all taps.
- Owns the coefficient RAM and the circular sample history.
- Accepts one sample per valid/ready handshake.
- Runs N MAC cycles, then emits one filtered output pulse.
- Sits between the sample source and downstream consumers in the FIR_filter datapath.

Parameters:
- N, 16, number of taps (>=2).
- DW, 16, signed sample and coefficient width.
- AW, $clog2(N), tap index width (derived; do not override).
- ACC_W, 2*DW+AW, signed accumulator and output width (no overflow possible).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- coeff_wr  in  1  coefficient write strobe.
- coeff_addr  in  AW  coefficient index; tap k multiplies the sample k steps old.
- coeff_in  in  DW  signed coefficient data.
- x_valid  in  1  sample offered.
- x_in  in  DW  signed sample.
- x_ready  out  1  sample accepted when x_valid && x_ready.
- y_valid  out  1  single-cycle pulse: y_out is new.
- y_out  out  ACC_W  signed filter result, held between pulses.
- busy  out  1  high while in MAC state.

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=IDLE, wptr=0, tap counter k=0, acc=0.
  - y_out=0, y_valid=0, busy=0.
  - All N history entries and all N coefficients cleared to 0.
  - Reset mid-MAC aborts the computation; no y_valid is produced.
- States: IDLE, MAC.
  - IDLE -> MAC on sample accept.
  - MAC -> IDLE after the tap-(N-1) product.
- x_ready = (state==IDLE) && !coeff_wr. This is combinational. coeff_wr has priority over a sample in the same cycle.
- Coefficient write: when state==IDLE and coeff_wr, coeff[coeff_addr] <= coeff_in. A coeff_wr during MAC is ignored, with no side effect. Out-of-range coeff_addr (>=N, non-power-of-two N) is ignored.
- Sample accept (edge E0):
  - hist[wptr] <= x_in.
  - acc <= 0, k <= 0.
  - rd index <= wptr.
- MAC cycle j (j=0..N-1):
  - acc <= acc + hist[rd]*coeff[j], full-precision signed product, sign-extended to ACC_W.
  - rd <= rd-1 modulo N, wrapping N-1 after 0.
- Final edge (j=N-1):
  - y_out <= acc + last product.
  - y_valid <= 1 for exactly one cycle.
  - wptr <= wptr+1 modulo N.
  - state <= IDLE.
- Latency: a sample accepted on edge E0 gives y_valid high during the cycle after edge E0+N. Max throughput is one sample per N+1 cycles. x_ready may be high in the same cycle that y_valid is high.
- Result: y[n] = sum over k=0..N-1 of coeff[k]*x[n-k], with pre-reset/startup history treated as 0.
- No back-pressure on y: the consumer must take y_out on the y_valid pulse.
- x_valid without x_ready: the sample is not consumed. The source must hold it.

Decomposition:
- Shared package fir_pkg holds:
  - the state enum (IDLE, MAC);
  - a clog2 helper;
  - the default DW/N constants, shared with the direct-form filter.
- One sub-module, fir_mac_unit, holds the DW x DW signed multiply plus the ACC_W accumulator with synchronous clear and enable.
- The scheduler holds the FSM, pointers, history array and coefficient array.

Test Plan:
All scenarios use N=4, DW=16.
1. Impulse response. Load coeff={3,-2,5,7}; send samples 1,0,0,0,0. Expect y_out = 3,-2,5,7,0, each after exactly N+1=5 cycles from accept.
2. Moving sum with wrap. Load coeff={1,1,1,1}; stream 10,20,30,40,50,60 back-to-back. Expect y = 10,30,60,100,140,180, one result per 5 cycles. Exercises wptr wrap-around.
3. Priority. In IDLE, assert coeff_wr(addr 2, 9) and x_valid together. Expect x_ready=0 that cycle, coeff[2]=9, and the sample accepted the next cycle. A coeff_wr during busy=1 must leave the coefficients unchanged.
4. Width extremes. All coeffs = -32768; four samples of -32768. Expect 4th y_out = 4*2^30 = 4294967296 exactly, with no wrap at ACC_W=34.
5. Reset mid-MAC. Assert rst 2 cycles after accept. Expect no y_valid, y_out=0, x_ready=1 the cycle after rst drops. The next impulse must see zeroed history and coeffs (y=0).
6. Handshake hold. Hold x_valid with x_in=5 through the MAC of the previous sample. Expect exactly one accept of 5, on the first IDLE cycle.
